// File: rtl/ncl_pkg.sv
// Shared dual-rail constants, FSM state encoding and rail encode/decode helpers
// for the NCL XOR wavefront controller.
package ncl_pkg;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_F    = 2'b01;
    localparam logic [1:0] DR_T    = 2'b10;
    localparam logic [1:0] DR_ILL  = 2'b11;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRV_D  = 3'd1,
        ST_WAIT_D = 3'd2,
        ST_DRV_N  = 3'd3,
        ST_WAIT_N = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // Single-rail bit to dual-rail DATA pair {true,false}
    function automatic logic [1:0] dr_enc(input logic b);
        return b ? DR_T : DR_F;
    endfunction

    // Dual-rail pair to single-rail value (true rail)
    function automatic logic dr_dec(input logic [1:0] p);
        return p[1];
    endfunction

endpackage

// File: rtl/ncl_xor_wave_ctrl_if.sv
// Request / response / datapath bundle of the NCL XOR wavefront controller.
// The controller takes the slave view; the surrounding environment the master view.
interface ncl_xor_wave_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [WIDTH-1:0]   req0_a;
    logic               req0_sub;
    logic [WIDTH-1:0]   req1_a;
    logic               req1_sub;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_r;
    logic               rsp_err;
    logic [2*WIDTH-1:0] dp_a;
    logic [1:0]         dp_sub;
    logic [2*WIDTH-1:0] dp_r;
    logic               busy;

    modport slave (
        input  req_valid, req0_a, req0_sub, req1_a, req1_sub, rsp_ready, dp_r,
        output req_ready, rsp_valid, rsp_id, rsp_r, rsp_err, dp_a, dp_sub, busy
    );

    modport master (
        output req_valid, req0_a, req0_sub, req1_a, req1_sub, rsp_ready, dp_r,
        input  req_ready, rsp_valid, rsp_id, rsp_r, rsp_err, dp_a, dp_sub, busy
    );
endinterface

// File: rtl/ncl_cmpl_det.sv
// Combinational completion detector over WIDTH dual-rail pairs:
// all pairs DATA, all pairs NULL, or any pair in the illegal 11 code.
module ncl_cmpl_det
    import ncl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH-1:0] dr,
    output logic               all_data,
    output logic               all_null,
    output logic               any_ill
);

    // Classify every rail pair and fold into the three summary flags
    always_comb begin
        all_data = 1'b1;
        all_null = 1'b1;
        any_ill  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            case (dr[2*i +: 2])
                DR_NULL: all_data = 1'b0;
                DR_T, DR_F: all_null = 1'b0;
                DR_ILL: begin
                    all_data = 1'b0;
                    all_null = 1'b0;
                    any_ill  = 1'b1;
                end
                default: begin
                    all_data = 1'b0;
                    all_null = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ncl_xor_wave_ctrl.sv
// Wavefront controller for the dual-rail r = a XOR sub stage: arbitrates two requesters,
// drives DATA then NULL, returns the decoded result. Optional macro: ILLEGAL_CHK_EN.
module ncl_xor_wave_ctrl
    import ncl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TMO_CYC = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    ncl_xor_wave_ctrl_if.slave bus
);

`ifdef ILLEGAL_CHK_EN
    localparam logic ILL_CHK = 1'b1;
`else
    localparam logic ILL_CHK = 1'b0;
`endif

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    state_e             state_r;
    state_e             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               rr_r;

    logic [1:0]         req_ready_r;
    logic               rsp_valid_r;
    logic               rsp_id_r;
    logic [WIDTH-1:0]   rsp_r_r;
    logic               rsp_err_r;
    logic [2*WIDTH-1:0] dp_a_r;
    logic [1:0]         dp_sub_r;
    logic               busy_r;

    logic [1:0]         req_ready_nx_s;
    logic               rsp_valid_nx_s;
    logic               rsp_id_nx_s;
    logic [WIDTH-1:0]   rsp_r_nx_s;
    logic               rsp_err_nx_s;
    logic [2*WIDTH-1:0] dp_a_nx_s;
    logic [1:0]         dp_sub_nx_s;
    logic               busy_nx_s;

    logic [1:0]         grant_s;
    logic               accept_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic               sel_sub_s;
    logic [2*WIDTH-1:0] enc_a_s;
    logic [WIDTH-1:0]   dec_r_s;
    logic               all_data_s;
    logic               all_null_s;
    logic               any_ill_s;
    logic               ill_s;
    logic               tmo_s;

    ncl_cmpl_det #(.WIDTH(WIDTH)) u_cmpl (
        .dr       (bus.dp_r),
        .all_data (all_data_s),
        .all_null (all_null_s),
        .any_ill  (any_ill_s)
    );

    // Illegal pairs only abort a wait when the check is built in
    assign ill_s    = any_ill_s & ILL_CHK;
    assign tmo_s    = (cnt_r == TMO_LAST);
    // req_ready is one-hot, so a handshake on either bit is the accept
    assign accept_s = (state_r == ST_IDLE) && (|(bus.req_valid & req_ready_r));

    // Round-robin grant offered on the next cycle's req_ready
    always_comb begin
        case (bus.req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = rr_r ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

    // Operand of the ready requester, its DATA encoding, and the decoded stage result
    always_comb begin
        enc_a_s = '0;
        dec_r_s = '0;
        if (req_ready_r[1]) begin
            sel_a_s   = bus.req1_a;
            sel_sub_s = bus.req1_sub;
        end else begin
            sel_a_s   = bus.req0_a;
            sel_sub_s = bus.req0_sub;
        end
        for (int i = 0; i < WIDTH; i++) begin
            enc_a_s[2*i +: 2] = dr_enc(sel_a_s[i]);
            dec_r_s[i]        = dr_dec(bus.dp_r[2*i +: 2]);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:   next_state_s = accept_s ? ST_DRV_D : ST_IDLE;
            ST_DRV_D:  next_state_s = ST_WAIT_D;
            ST_WAIT_D: next_state_s = (all_data_s || ill_s || tmo_s) ? ST_DRV_N : ST_WAIT_D;
            ST_DRV_N:  next_state_s = ST_WAIT_N;
            ST_WAIT_N: next_state_s = (all_null_s || ill_s || tmo_s) ? ST_RESP : ST_WAIT_N;
            ST_RESP:   next_state_s = bus.rsp_ready ? ST_IDLE : ST_RESP;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, keyed on the transition taken
    always_comb begin
        dp_a_nx_s      = dp_a_r;
        dp_sub_nx_s    = dp_sub_r;
        rsp_id_nx_s    = rsp_id_r;
        rsp_r_nx_s     = rsp_r_r;
        rsp_err_nx_s   = rsp_err_r;
        rsp_valid_nx_s = (next_state_s == ST_RESP);
        busy_nx_s      = (next_state_s != ST_IDLE);
        if (next_state_s == ST_IDLE) begin
            req_ready_nx_s = grant_s;
        end else begin
            req_ready_nx_s = 2'b00;
        end
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    dp_a_nx_s    = enc_a_s;
                    dp_sub_nx_s  = dr_enc(sel_sub_s);
                    rsp_id_nx_s  = req_ready_r[1];
                    rsp_r_nx_s   = '0;
                    rsp_err_nx_s = 1'b0;
                end else begin
                    rsp_id_nx_s  = rsp_id_r;
                end
            end
            ST_WAIT_D: begin
                // Completion wins; a timed-out or corrupted wavefront still gets a NULL phase
                if (all_data_s) begin
                    rsp_r_nx_s  = dec_r_s;
                    dp_a_nx_s   = '0;
                    dp_sub_nx_s = DR_NULL;
                end else if (ill_s || tmo_s) begin
                    rsp_r_nx_s   = '0;
                    rsp_err_nx_s = 1'b1;
                    dp_a_nx_s    = '0;
                    dp_sub_nx_s  = DR_NULL;
                end else begin
                    rsp_r_nx_s = rsp_r_r;
                end
            end
            ST_WAIT_N: begin
                if (!all_null_s && (ill_s || tmo_s)) begin
                    rsp_err_nx_s = 1'b1;
                end else begin
                    rsp_err_nx_s = rsp_err_r;
                end
            end
            default: begin
                rsp_err_nx_s = rsp_err_r;
            end
        endcase
    end

    // Wait-state cycle counter (zero on every WAIT entry) and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            rr_r  <= 1'b0;
        end else begin
            if ((state_r == ST_WAIT_D) || (state_r == ST_WAIT_N)) begin
                if (cnt_r != {CNT_W{1'b1}}) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end else begin
                cnt_r <= '0;
            end
            if (accept_s) begin
                rr_r <= ~req_ready_r[1];
            end else begin
                rr_r <= rr_r;
            end
        end
    end

    // Output registers; reset forces the datapath lines to NULL immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r <= 2'b00;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_r_r     <= '0;
            rsp_err_r   <= 1'b0;
            dp_a_r      <= '0;
            dp_sub_r    <= DR_NULL;
            busy_r      <= 1'b0;
        end else begin
            req_ready_r <= req_ready_nx_s;
            rsp_valid_r <= rsp_valid_nx_s;
            rsp_id_r    <= rsp_id_nx_s;
            rsp_r_r     <= rsp_r_nx_s;
            rsp_err_r   <= rsp_err_nx_s;
            dp_a_r      <= dp_a_nx_s;
            dp_sub_r    <= dp_sub_nx_s;
            busy_r      <= busy_nx_s;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_r     = rsp_r_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.dp_a      = dp_a_r;
    assign bus.dp_sub    = dp_sub_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_ncl_xor_wave_ctrl.sv
// Directed bench for ncl_xor_wave_ctrl with a registered dual-rail XOR stage model
// (ideal / stuck-NULL / pair0-illegal modes). Honours ILLEGAL_CHK_EN for expectations.
module tb_ncl_xor_wave_ctrl;

    localparam int TMO = 15;
    // Accept edge counts as 1; ideal stage gives 5, a timeout 4 edges beyond TMO
`ifdef ILLEGAL_CHK_EN
    localparam int ILL_LAT = 5;
`else
    localparam int ILL_LAT = TMO + 4;
`endif

    logic       clk;
    logic       rst_n;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         mode    = 0;
    logic [1:0] acc_v;
    int         lat_v;

    ncl_xor_wave_ctrl_if #(.WIDTH(4)) bus ();

    ncl_xor_wave_ctrl #(.WIDTH(4), .TMO_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] stage(input logic [7:0] a, input logic [1:0] s);
        logic [7:0] res;
        res = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (a[2*i +: 2] == 2'b00 || s == 2'b00) res[2*i +: 2] = 2'b00;
            else if (a[2*i+1] ^ s[1])               res[2*i +: 2] = 2'b10;
            else                                    res[2*i +: 2] = 2'b01;
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               bus.dp_r <= 8'h00;
        else if (mode == 1)                       bus.dp_r <= 8'h00;
        else if (mode == 2 && bus.dp_a != 8'h00)  bus.dp_r <= stage(bus.dp_a, bus.dp_sub) | 8'h03;
        else                                      bus.dp_r <= stage(bus.dp_a, bus.dp_sub);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] vld, input logic [3:0] a0, input logic s0,
                            input logic [3:0] a1, input logic s1, input logic keep,
                            output logic [1:0] acc);
        bus.req0_a = a0; bus.req0_sub = s0;
        bus.req1_a = a1; bus.req1_sub = s1;
        bus.req_valid = vld;
        acc = 2'b00;
        for (int k = 0; k < 10; k++) begin
            if (|(bus.req_valid & bus.req_ready)) begin
                acc = bus.req_valid & bus.req_ready;
                break;
            end
            @(negedge clk);
        end
        chk("accept_seen", 32'(acc != 2'b00), 32'd1);
        if (acc != 2'b00) begin
            @(posedge clk);
            #1;
            if (!keep) bus.req_valid = 2'b00;
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [1:0] vld,
                            input logic [3:0] a0, input logic s0, input logic [3:0] a1, input logic s1,
                            input logic keep, input logic [1:0] exp_acc, input logic [3:0] exp_r,
                            input logic exp_err, input int exp_lat);
        logic [1:0] acc;
        int lat;
        start_op(vld, a0, s0, a1, s1, keep, acc);
        wait_rsp(lat);
        chk({tag, "_grant"}, 32'(acc), 32'(exp_acc));
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(bus.rsp_id), 32'(exp_acc[1]));
        chk({tag, "_r"}, 32'(bus.rsp_r), 32'(exp_r));
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        consume();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
        bus.req0_a = 4'h0; bus.req0_sub = 1'b0; bus.req1_a = 4'h0; bus.req1_sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_dp_a", 32'(bus.dp_a), 32'd0);
        chk("rst_dp_sub", 32'(bus.dp_sub), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both requesters valid back to back: 0,1,0,1
        op_check("b2b0", 2'b11, 4'b0011, 1'b0, 4'b1001, 1'b1, 1'b1, 2'b01, 4'b0011, 1'b0, 5);
        op_check("b2b1", 2'b11, 4'b0011, 1'b0, 4'b1001, 1'b1, 1'b1, 2'b10, 4'b0110, 1'b0, 5);
        op_check("b2b2", 2'b11, 4'b0011, 1'b0, 4'b1001, 1'b1, 1'b1, 2'b01, 4'b0011, 1'b0, 5);
        op_check("b2b3", 2'b11, 4'b0011, 1'b0, 4'b1001, 1'b1, 1'b0, 2'b10, 4'b0110, 1'b0, 5);

        op_check("single0", 2'b01, 4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b01, 4'b1010, 1'b0, 5);

        // Consumer stalls with both requesters still asking
        start_op(2'b11, 4'b0000, 1'b0, 4'b1110, 1'b0, 1'b1, acc_v);
        wait_rsp(lat_v);
        chk("hold_grant", 32'(acc_v), 32'h2);
        chk("hold_lat", 32'(lat_v), 32'd5);
        for (int k = 0; k < 10; k++) begin
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_r", 32'(bus.rsp_r), 32'hE);
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        consume();
        chk("regrant_ready", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("drop_ready", 32'(bus.req_ready), 32'd0);
        chk("drop_busy", 32'(bus.busy), 32'd0);
        op_check("ptr_keep", 2'b11, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b01, 4'b0111, 1'b0, 5);

        // Stage stuck at NULL: WAIT_D timeout
        mode = 1;
        op_check("tmo", 2'b01, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b1, TMO + 4);
        chk("tmo_idle_busy", 32'(bus.busy), 32'd0);
        chk("tmo_idle_valid", 32'(bus.rsp_valid), 32'd0);

        // Pair 0 returns the illegal code during the DATA wavefront
        mode = 2;
        op_check("ill", 2'b01, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b1, ILL_LAT);

        // Reset while waiting for DATA completion
        mode = 1;
        start_op(2'b01, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, acc_v);
        chk("mid_grant", 32'(acc_v), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_dp_a", 32'(bus.dp_a), 32'hAA);
        chk("mid_dp_sub", 32'(bus.dp_sub), 32'h1);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_dp_a", 32'(bus.dp_a), 32'd0);
        chk("arst_dp_sub", 32'(bus.dp_sub), 32'd0);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        @(negedge clk);
        op_check("post_rst", 2'b11, 4'b0110, 1'b1, 4'b0001, 1'b0, 1'b0, 2'b01, 4'b1001, 1'b0, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
